// File: rtl/extend_unit_pipe_if.sv
// Operand/result handshake bundle for the extend unit.
// master = upstream/downstream environment, slave = the extend unit itself.
interface extend_unit_pipe_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 64,
    parameter int unsigned CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [1:0]        in_size;
    logic              in_signed;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_err;
    logic [CNT_W-1:0]  xfer_count;

    modport master (
        output in_valid, in_data, in_size, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_err, xfer_count
    );

    modport slave (
        input  in_valid, in_data, in_size, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_err, xfer_count
    );
endinterface

// File: rtl/extend_unit_pipe.sv
// Flow-controlled sign/zero extender: IN_W-bit operand with per-item size and signedness,
// OUT_W-bit registered result, 2-entry skid buffer for full-throughput backpressure.
module extend_unit_pipe #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 64,
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    extend_unit_pipe_if.slave bus
);

    // EMPTY: nothing held; ONE: main holds the presented result; FULL: main and skid both held.
    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e             state_q, state_d;
    logic               in_ready_int, out_valid_int;
    logic               accept, out_hs;
    logic               load_main_new, load_main_skid, load_skid;
    int                 eff_w;
    logic               sign_bit;
    logic [OUT_W-1:0]   ext_data;
    logic               ext_err;
    logic [OUT_W-1:0]   main_data_q, skid_data_q;
    logic               main_err_q, skid_err_q;
    logic [CNT_W-1:0]   count_q;

    // Extend the incoming operand combinationally so it can be registered on acceptance.
    always_comb begin
        ext_err = 1'b0;
        unique case (bus.in_size)
            2'b00:   eff_w = 8;
            2'b01:   eff_w = 16;
            2'b10:   eff_w = 32;
            default: eff_w = int'(IN_W);
        endcase
        // Requests wider than the operand clamp to IN_W and flag the item.
        if (eff_w > int'(IN_W)) begin
            eff_w   = int'(IN_W);
            ext_err = 1'b1;
        end
        sign_bit = 1'b0;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (i == eff_w - 1) sign_bit = bus.in_data[i];
        end
        ext_data = {OUT_W{bus.in_signed & sign_bit}};
        for (int i = 0; i < int'(IN_W); i++) begin
            if (i < eff_w) ext_data[i] = bus.in_data[i];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StEmpty;
        else        state_q <= state_d;
    end

    // Next-state: occupancy follows accepts and output handshakes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StOne;
            StOne: begin
                if (accept && !out_hs)      state_d = StFull;
                else if (!accept && out_hs) state_d = StEmpty;
            end
            StFull:  if (out_hs) state_d = StOne;
            default: state_d = StEmpty;
        endcase
    end

    // Outputs and datapath load controls; in_ready depends on the state flop only.
    always_comb begin
        in_ready_int   = (state_q != StFull);
        out_valid_int  = (state_q != StEmpty);
        accept         = bus.in_valid && in_ready_int;
        out_hs         = out_valid_int && bus.out_ready;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            StEmpty: load_main_new = accept;
            StOne: begin
                load_main_new = accept && out_hs;
                load_skid     = accept && !out_hs;
            end
            StFull:  load_main_skid = out_hs;
            default: ;
        endcase
    end

    // Main/skid data registers and the completed-transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            if (load_main_new) begin
                main_data_q <= ext_data;
                main_err_q  <= ext_err;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_err_q  <= skid_err_q;
            end
            if (load_skid) begin
                skid_data_q <= ext_data;
                skid_err_q  <= ext_err;
            end
            if (out_hs) count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.out_valid  = out_valid_int;
    assign bus.out_data   = main_data_q;
    assign bus.out_err    = main_err_q;
    assign bus.xfer_count = count_q;

endmodule

// File: tb/tb_extend_unit_pipe.sv
// Scoreboard bench: dut0 is the 32->64 build, dut1 the IN_W=16 / CNT_W=4 build.
module tb_extend_unit_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    extend_unit_pipe_if #(.IN_W(32), .OUT_W(64), .CNT_W(16)) bus0 ();
    extend_unit_pipe_if #(.IN_W(16), .OUT_W(64), .CNT_W(4))  bus1 ();

    extend_unit_pipe #(.IN_W(32), .OUT_W(64), .CNT_W(16)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    extend_unit_pipe #(.IN_W(16), .OUT_W(64), .CNT_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference for the 32-bit build (size 11 equals 32 bits there).
    function automatic logic [63:0] model32(input logic [31:0] d, input logic [1:0] s,
                                            input logic sg);
        case (s)
            2'b00:   return sg ? {{56{d[7]}}, d[7:0]}   : {56'd0, d[7:0]};
            2'b01:   return sg ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
            default: return sg ? {{32{d[31]}}, d}       : {32'd0, d};
        endcase
    endfunction

    // Monitors: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && bus0.out_valid && bus0.out_ready) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0 unexpected output: got %h expected none", bus0.out_data);
            end else begin
                e0 = q0.pop_front();
                check("dut0 out_data", bus0.out_data, e0.data);
                check("dut0 out_err", {63'd0, bus0.out_err}, {63'd0, e0.err});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected output: got %h expected none", bus1.out_data);
            end else begin
                e1 = q1.pop_front();
                check("dut1 out_data", bus1.out_data, e1.data);
                check("dut1 out_err", {63'd0, bus1.out_err}, {63'd0, e1.err});
            end
        end
    end

    // Present one item from posedge+1 until accepted; expectation is queued on acceptance.
    task automatic send(input int which, input logic [31:0] data, input logic [1:0] size,
                        input logic sgn, input logic [63:0] exp_data, input logic exp_err,
                        input bit must_accept);
        exp_t e;
        bit   done;
        logic rdy;
        e.data = exp_data;
        e.err  = exp_err;
        done   = 1'b0;
        if (which == 0) begin
            bus0.in_valid = 1'b1; bus0.in_data = data; bus0.in_size = size; bus0.in_signed = sgn;
        end else begin
            bus1.in_valid = 1'b1; bus1.in_data = data[15:0]; bus1.in_size = size;
            bus1.in_signed = sgn;
        end
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            rdy = (which == 0) ? bus0.in_ready : bus1.in_ready;
            if (must_accept && c == 0) check("in_ready while streaming", {63'd0, rdy}, 64'd1);
            if (rdy) begin
                if (which == 0) q0.push_back(e);
                else            q1.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send timeout: got in_ready=0 expected accept within 50 cycles");
        end
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_size = '0; bus0.in_signed = 1'b0;
        bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_size = '0; bus1.in_signed = 1'b0;
        bus1.out_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        check("reset out_valid", {63'd0, bus0.out_valid}, 64'd0);
        check("reset out_data", bus0.out_data, 64'd0);
        check("reset in_ready", {63'd0, bus0.in_ready}, 64'd1);
        check("reset xfer_count", 64'(bus0.xfer_count), 64'd0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);

        // Extension modes.
        send(0, 32'h0000_0080, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b1);
        send(0, 32'h0000_0080, 2'b00, 1'b0, 64'h0000_0000_0000_0080, 1'b0, 1'b1);
        send(0, 32'h1234_8001, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b1);
        send(0, 32'h8000_0000, 2'b10, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1);
        wait_cycles(2);
        check("modes drained", 64'(q0.size()), 64'd0);
        check("modes xfer_count", 64'(bus0.xfer_count), 64'd4);

        // Backpressure: A then B with out_ready low fills main and skid.
        bus0.out_ready = 1'b0;
        send(0, 32'h0000_00AA, 2'b11, 1'b0, 64'h0000_0000_0000_00AA, 1'b0, 1'b0);
        send(0, 32'hBBBB_BBBB, 2'b11, 1'b1, 64'hFFFF_FFFF_BBBB_BBBB, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full in_ready", {63'd0, bus0.in_ready}, 64'd0);
            check("stalled out_valid", {63'd0, bus0.out_valid}, 64'd1);
            check("stalled out_data", bus0.out_data, 64'h0000_0000_0000_00AA);
        end
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b1;
        wait_cycles(3);
        check("backpressure in_ready", {63'd0, bus0.in_ready}, 64'd1);
        check("backpressure drained", 64'(q0.size()), 64'd0);
        check("backpressure xfer_count", 64'(bus0.xfer_count), 64'd6);

        // Asynchronous reset while FULL.
        bus0.out_ready = 1'b0;
        send(0, 32'h0000_0011, 2'b00, 1'b0, 64'h11, 1'b0, 1'b0);
        send(0, 32'h0000_0022, 2'b00, 1'b0, 64'h22, 1'b0, 1'b0);
        check("pre-reset in_ready", {63'd0, bus0.in_ready}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", {63'd0, bus0.out_valid}, 64'd0);
        check("async reset xfer_count", 64'(bus0.xfer_count), 64'd0);
        check("async reset in_ready", {63'd0, bus0.in_ready}, 64'd1);
        q0.delete();
        q1.delete();
        wait_cycles(1);
        rst_n = 1'b1;
        bus0.out_ready = 1'b1;
        wait_cycles(1);

        // Streaming: 100 back-to-back items.
        for (int i = 0; i < 100; i++) begin
            logic [31:0] d;
            logic [1:0]  s;
            logic        sg;
            d  = 32'h9E37_79B9 * (i + 1);
            s  = 2'(i % 4);
            sg = (i % 3) != 0;
            send(0, d, s, sg, model32(d, s, sg), 1'b0, 1'b1);
        end
        wait_cycles(2);
        check("stream drained", 64'(q0.size()), 64'd0);
        check("stream xfer_count", 64'(bus0.xfer_count), 64'd100);

        // IN_W=16 build: oversized request clamps and flags.
        send(1, 32'h0000_8001, 2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b1);
        send(1, 32'h0000_8001, 2'b11, 1'b0, 64'h0000_0000_0000_8001, 1'b0, 1'b1);
        send(1, 32'h0000_12F0, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) begin
            send(1, 32'(i), 2'b00, 1'b0, 64'(i), 1'b0, 1'b1);
        end
        wait_cycles(2);
        check("cnt4 after 16", 64'(bus1.xfer_count), 64'd0);
        send(1, 32'h0000_7F00, 2'b01, 1'b1, 64'h0000_0000_0000_7F00, 1'b0, 1'b1);
        wait_cycles(2);
        check("cnt4 after 17", 64'(bus1.xfer_count), 64'd1);
        check("dut1 drained", 64'(q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
